clk_gen: RTL and testbench

CLK_GEN -- requirements
Module: clk_gen

---
 rtl/clk_gen_pkg.sv | 23 ++
 rtl/clk_gen_if.sv | 16 +
 rtl/clk_gen_ch.sv | 62 ++++++
 rtl/clk_gen.sv | 171 +++++++++++++++++
 tb/tb_clk_gen.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types for the clock generator: CPU clock mode encoding and the
// clock-switch FSM states, plus a helper for the channel-index width.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        MODE_FAST = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_STEP = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SW_RUN    = 2'd0,
        SW_DRAIN  = 2'd1,
        SW_SWITCH = 2'd2
    } sw_state_e;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int unsigned chIdxWidth(input int unsigned nCh);
        return (nCh > 1) ? $clog2(nCh) : 1;
    endfunction

endpackage

// File: rtl/clk_gen_if.sv
// Configuration bus used to program the per-channel divide registers.
interface clk_gen_if
    import clk_gen_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DIV_W = 16
);
    localparam int CH_W = chIdxWidth(N_CH);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_we, output cfg_ch, output cfg_div);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_div);
endinterface

// File: rtl/clk_gen_ch.sv
// One programmable divided-clock channel: a divide register, a counter that
// runs 0..D, a 50%-duty toggle output and a one-cycle tick on each toggle.
// A divide value of zero parks the channel with everything held low.
module clk_gen_ch #(
    parameter int          DIV_W    = 16,
    parameter int unsigned DIV_INIT = 49999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ch_clk_o,
    output logic             ch_tick_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    // Next-state: a write restarts the channel, zero divide disables it,
    // otherwise count up and toggle when the count reaches the divide value.
    always_comb begin
        div_d  = div_q;
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (we_i) begin
            div_d = div_i;
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (div_q == '0) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Channel registers; reset loads the default divide value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= DIV_W'(DIV_INIT);
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign ch_clk_o  = clk_q;
    assign ch_tick_o = tick_q;

endmodule

// File: rtl/clk_gen.sv
// Clock generator: free-running divider counter, N programmable divided
// channels, and a glitch-free CPU clock selected between a fast counter bit,
// channel 0, a push-button single-step pulse, or a held-low level.
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter int          N_CH     = 4,
    parameter int          DIV_W    = 16,
    parameter int unsigned DIV_INIT = 49999,
    parameter int          FAST_BIT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    clk_gen_if.slave          cfg,
    input  logic [1:0]        mode,
    input  logic              step,
    output logic [CNT_W-1:0]  clkdiv,
    output logic [N_CH-1:0]   ch_clk,
    output logic [N_CH-1:0]   ch_tick,
    output logic              clk_cpu,
    output logic [1:0]        mode_act
);

    localparam int          PW       = (FAST_BIT > 0) ? FAST_BIT : 1;
    localparam logic [PW-1:0] STEP_LAST = PW'((1 << FAST_BIT) - 1);

    logic [CNT_W-1:0] clkdiv_q;
    logic [2:0]       stepSync_q;
    logic             stepRise;
    logic             stepSrc_q, stepSrc_d;
    logic [PW-1:0]    stepCnt_q, stepCnt_d;
    sw_state_e        swState_q, swState_d;
    mode_e            target_q, target_d;
    mode_e            modeAct_q, modeAct_d;
    mode_e            modeReq;
    logic             clkCpu_q, clkCpu_d;
    logic [3:0]       srcVec;
    logic             curSrc;
    logic             tgtSrc;

    // Free-running divider counter, wraps naturally at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv_q <= '0;
        end else begin
            clkdiv_q <= clkdiv_q + CNT_W'(1);
        end
    end

    assign clkdiv = clkdiv_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic chWe;
        assign chWe = cfg.cfg_we && (32'(cfg.cfg_ch) == 32'(i));

        clk_gen_ch #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_INIT)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .we_i      (chWe),
            .div_i     (cfg.cfg_div),
            .ch_clk_o  (ch_clk[i]),
            .ch_tick_o (ch_tick[i])
        );
    end

    // Two-flop synchroniser for the step button plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stepSync_q <= '0;
        end else begin
            stepSync_q <= {stepSync_q[1:0], step};
        end
    end

    assign stepRise = stepSync_q[1] & ~stepSync_q[2];

    // Step pulse: a fresh edge while settled in STEP starts a fixed-length pulse; busy edges are dropped.
    always_comb begin
        stepSrc_d = stepSrc_q;
        stepCnt_d = stepCnt_q;
        if (stepSrc_q) begin
            if (stepCnt_q == '0) begin
                stepSrc_d = 1'b0;
            end else begin
                stepCnt_d = stepCnt_q - PW'(1);
            end
        end else if (stepRise && modeAct_q == MODE_STEP && swState_q == SW_RUN) begin
            stepSrc_d = 1'b1;
            stepCnt_d = STEP_LAST;
        end
    end

    // Step pulse generator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stepSrc_q <= 1'b0;
            stepCnt_q <= '0;
        end else begin
            stepSrc_q <= stepSrc_d;
            stepCnt_q <= stepCnt_d;
        end
    end

    assign modeReq = mode_e'(mode);
    assign srcVec  = {1'b0, stepSrc_q, ch_clk[0], clkdiv_q[FAST_BIT]};
    assign curSrc  = srcVec[modeAct_q];
    assign tgtSrc  = srcVec[target_q];

    // Switch FSM state register together with the active mode and the registered CPU clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swState_q <= SW_RUN;
            target_q  <= MODE_FAST;
            modeAct_q <= MODE_FAST;
            clkCpu_q  <= 1'b0;
        end else begin
            swState_q <= swState_d;
            target_q  <= target_d;
            modeAct_q <= modeAct_d;
            clkCpu_q  <= clkCpu_d;
        end
    end

    // Next state: leave the old source only once it is low, enter the new one only once it is low too.
    always_comb begin
        swState_d = swState_q;
        target_d  = target_q;
        modeAct_d = modeAct_q;
        case (swState_q)
            SW_RUN: begin
                if (modeReq != modeAct_q) begin
                    target_d  = modeReq;
                    swState_d = SW_DRAIN;
                end
            end
            SW_DRAIN: begin
                if (!curSrc) begin
                    swState_d = SW_SWITCH;
                end
            end
            SW_SWITCH: begin
                if (!tgtSrc) begin
                    modeAct_d = target_q;
                    swState_d = SW_RUN;
                end
            end
            default: begin
                swState_d = SW_RUN;
            end
        endcase
    end

    // Output: follow the active source while running or draining a high phase, hold low while switching.
    always_comb begin
        clkCpu_d = 1'b0;
        case (swState_q)
            SW_RUN:    clkCpu_d = curSrc;
            SW_DRAIN:  clkCpu_d = curSrc;
            SW_SWITCH: clkCpu_d = 1'b0;
            default:   clkCpu_d = 1'b0;
        endcase
    end

    assign clk_cpu  = clkCpu_q;
    assign mode_act = modeAct_q;

endmodule

// File: tb/tb_clk_gen.sv
// Testbench for clk_gen: an arithmetic reference model pushes the expected
// counter/channel/CPU-clock values each cycle into a scoreboard queue, a
// monitor pops and compares them, and directed phases exercise mode switching,
// single-step pulses and asynchronous reset.
module tb_clk_gen;

    localparam int CNT_W    = 8;
    localparam int N_CH     = 3;
    localparam int DIV_W    = 16;
    localparam int DIV_INIT = 9;
    localparam int FAST_BIT = 2;
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef struct {
        logic [CNT_W-1:0] clkdiv;
        logic [N_CH-1:0]  chClk;
        logic [N_CH-1:0]  chTick;
        int               cpuChk;
        logic             cpu;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             step = 1'b0;
    logic [CNT_W-1:0] clkdiv;
    logic [N_CH-1:0]  ch_clk;
    logic [N_CH-1:0]  ch_tick;
    logic             clk_cpu;
    logic [1:0]       mode_act;

    int   compared = 0;
    int   mismatched = 0;
    int   cpuCheck = 0;
    exp_t expQ[$];
    int   pulseW[$];

    clk_gen_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cfg ();

    clk_gen #(
        .CNT_W    (CNT_W),
        .N_CH     (N_CH),
        .DIV_W    (DIV_W),
        .DIV_INIT (DIV_INIT),
        .FAST_BIT (FAST_BIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg      (cfg),
        .mode     (mode),
        .step     (step),
        .clkdiv   (clkdiv),
        .ch_clk   (ch_clk),
        .ch_tick  (ch_tick),
        .clk_cpu  (clk_cpu),
        .mode_act (mode_act)
    );

    // Free-running system clock.
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of configuration stimulus; the write strobe drops after the cycle.
    task automatic applyStimulus(input logic we, input int ch, input int div);
        cfg.cfg_we  = we;
        cfg.cfg_ch  = CH_W'(ch);
        cfg.cfg_div = DIV_W'(div);
        @(posedge clk);
        #1;
        cfg.cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 0);
    endtask

    task automatic waitModeAct(input logic [1:0] m, input int limit);
        int n = 0;
        while (mode_act !== m && n < limit) begin
            applyStimulus(1'b0, 0, 0);
            n++;
        end
        checkOutput("modeActSettle", 32'(mode_act), 32'(m));
    endtask

    task automatic waitCpuHigh(input int limit);
        int n = 0;
        while (clk_cpu !== 1'b1 && n < limit) begin
            applyStimulus(1'b0, 0, 0);
            n++;
        end
        checkOutput("cpuHighSeen", 32'(clk_cpu), 32'd1);
    endtask

    task automatic watchLow(input int n, input string name);
        logic sawHigh = 1'b0;
        repeat (n) begin
            applyStimulus(1'b0, 0, 0);
            if (clk_cpu !== 1'b0) sawHigh = 1'b1;
        end
        checkOutput(name, 32'(sawHigh), 32'd0);
    endtask

    // Reference model: every output is a closed-form function of edges since reset or last write.
    initial begin : model
        logic [CNT_W-1:0] kCyc;
        int unsigned      chD[N_CH];
        int unsigned      chN[N_CH];
        logic             oldBit2;
        logic             oldCh0;
        logic             lastCh0;
        exp_t             e;
        kCyc    = '0;
        lastCh0 = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            chD[i] = DIV_INIT;
            chN[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                kCyc    = '0;
                lastCh0 = 1'b0;
                for (int i = 0; i < N_CH; i++) begin
                    chD[i] = DIV_INIT;
                    chN[i] = 0;
                end
                expQ.delete();
            end else begin
                oldBit2 = kCyc[FAST_BIT];
                oldCh0  = lastCh0;
                kCyc    = kCyc + 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    if (cfg.cfg_we && int'(cfg.cfg_ch) == i) begin
                        chD[i] = cfg.cfg_div;
                        chN[i] = 0;
                    end else if (chD[i] != 0) begin
                        chN[i]++;
                    end
                end
                e.clkdiv = kCyc;
                e.chClk  = '0;
                e.chTick = '0;
                for (int i = 0; i < N_CH; i++) begin
                    if (chD[i] != 0) begin
                        e.chClk[i]  = ((chN[i] / (chD[i] + 1)) % 2) == 1;
                        e.chTick[i] = (chN[i] != 0) && (chN[i] % (chD[i] + 1) == 0);
                    end
                end
                lastCh0  = e.chClk[0];
                e.cpuChk = cpuCheck;
                e.cpu    = (cpuCheck == 2) ? oldCh0 : oldBit2;
                expQ.push_back(e);
            end
        end
    end

    // Scoreboard monitor: pops one expectation per cycle and compares away from the clock edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("clkdiv", 32'(clkdiv), 32'(e.clkdiv));
                checkOutput("chClk", 32'(ch_clk), 32'(e.chClk));
                checkOutput("chTick", 32'(ch_tick), 32'(e.chTick));
                if (e.cpuChk == 2) checkOutput("cpuSlow", 32'(clk_cpu), 32'(e.cpu));
                else if (e.cpuChk == 1) checkOutput("cpuFast", 32'(clk_cpu), 32'(e.cpu));
            end
        end
    end

    // Every completed CPU high phase must be a full source high phase, never a runt.
    initial begin : pulseMon
        int run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (clk_cpu === 1'b1) begin
                run++;
            end else if (run > 0) begin
                pulseW.push_back(run);
                checkOutput("cpuHighMin", 32'(run >= 4), 32'd1);
                run = 0;
            end
        end
    end

    initial begin : stimulus
        cfg.cfg_we  = 1'b0;
        cfg.cfg_ch  = '0;
        cfg.cfg_div = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstClkdiv", 32'(clkdiv), 32'd0);
        checkOutput("rstChClk", 32'(ch_clk), 32'd0);
        checkOutput("rstChTick", 32'(ch_tick), 32'd0);
        checkOutput("rstCpu", 32'(clk_cpu), 32'd0);
        checkOutput("rstModeAct", 32'(mode_act), 32'd0);

        cpuCheck = 1;
        rst_n = 1'b1;
        idle(40);

        applyStimulus(1'b1, 1, 3);
        idle(24);
        applyStimulus(1'b1, 2, 0);
        idle(12);
        applyStimulus(1'b1, N_CH, 7);
        idle(20);

        repeat (300) begin
            if ($urandom_range(0, 5) == 0) begin
                applyStimulus(1'b1, int'($urandom_range(0, N_CH)),
                              ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12)));
            end else begin
                applyStimulus(1'b0, 0, 0);
            end
        end

        applyStimulus(1'b1, 0, 5);
        idle(15);

        waitCpuHigh(12);
        cpuCheck = 0;
        mode = 2'd1;
        applyStimulus(1'b0, 0, 0);
        checkOutput("modeActHeld", 32'(mode_act), 32'd0);
        waitModeAct(2'd1, 60);
        idle(2);
        cpuCheck = 2;
        idle(40);

        cpuCheck = 0;
        for (int i = 0; i < 10; i++) begin
            mode = (i % 2 == 0) ? 2'd1 : 2'd0;
            idle(3);
        end
        idle(60);
        checkOutput("modeActFinal", 32'(mode_act), 32'd0);
        cpuCheck = 1;
        idle(30);

        cpuCheck = 0;
        mode = 2'd3;
        waitModeAct(2'd3, 16);
        watchLow(20, "holdLow");

        mode = 2'd2;
        waitModeAct(2'd2, 8);
        watchLow(10, "stepIdleLow");
        pulseW.delete();
        step = 1'b1;
        idle(2);
        step = 1'b0;
        idle(1);
        step = 1'b1;
        idle(2);
        step = 1'b0;
        idle(50 + int'($urandom_range(0, 5)));
        step = 1'b1;
        idle(3);
        step = 1'b0;
        idle(50 + int'($urandom_range(0, 5)));
        step = 1'b1;
        idle(3);
        step = 1'b0;
        idle(20);
        checkOutput("stepPulseCount", 32'(pulseW.size()), 32'd3);
        foreach (pulseW[k]) checkOutput("stepPulseWidth", 32'(pulseW[k]), 32'd4);

        step = 1'b1;
        waitCpuHigh(10);
        idle(1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abortCpu", 32'(clk_cpu), 32'd0);
        checkOutput("abortModeAct", 32'(mode_act), 32'd0);
        checkOutput("abortClkdiv", 32'(clkdiv), 32'd0);
        checkOutput("abortChClk", 32'(ch_clk), 32'd0);
        step = 1'b0;
        mode = 2'd0;
        cpuCheck = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
